// File: rtl/stepper_pkg.sv
// stepper_pkg: state encoding, default widths and counter sizing shared by the stepper axis files
package stepper_pkg;

    typedef enum logic [1:0] {IDLE, DIR_SETUP, WAIT_TICK, PULSE} stepper_state_t;

    localparam int POS_W_DEFAULT = 16;

    typedef logic signed [POS_W_DEFAULT-1:0] pos_t;

    // Bits needed to hold the larger of two cycle counts
    function automatic int cnt_width(input int a, input int b);
        return $clog2(((a > b) ? a : b) + 1);
    endfunction

endpackage

// File: rtl/stepper_axis_ctrl_step_pulse_timer.sv
// step_pulse_timer: loadable down-counter with zero flag, shared by DIR setup and STEP pulse timing
module step_pulse_timer
    import stepper_pkg::*;
#(
    parameter int CNT_W = cnt_width(200, 100)
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_value,
    input  logic             i_dec,
    output logic             o_zero
);

    logic [CNT_W-1:0] r_count;

    // Load wins over decrement; decrement stops at zero
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) r_count <= '0;
        else if (i_load) r_count <= i_value;
        else if (i_dec && r_count != '0) r_count <= r_count - 1'b1;
    end

    assign o_zero = (r_count == '0);

endmodule

// File: rtl/stepper_axis_ctrl.sv
// stepper_axis_ctrl: single-axis STEP/DIR sequencer with position tracking; optional limits via STEPPER_LIMIT_EN
module stepper_axis_ctrl
    import stepper_pkg::*;
#(
    parameter int POS_W            = POS_W_DEFAULT,
    parameter int PULSE_CYCLES     = 200,
    parameter int DIR_SETUP_CYCLES = 100
) (
    input  logic                    clk_100mhz,
    input  logic                    rst_n,
    input  logic                    enable_step,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic signed [POS_W-1:0] cmd_target,
    input  logic                    abort,
    output logic                    step_out,
    output logic                    dir_out,
    output logic                    busy,
    output logic                    done,
    output logic signed [POS_W-1:0] position
`ifdef STEPPER_LIMIT_EN
    ,
    input  logic                    limit_lo_n,
    input  logic                    limit_hi_n,
    output logic                    fault
`endif
);

    localparam int CNT_W = cnt_width(PULSE_CYCLES, DIR_SETUP_CYCLES);
    // Counter runs N-1..0 so each phase lasts exactly N cycles
    localparam logic [CNT_W-1:0] SETUP_LOAD = CNT_W'(DIR_SETUP_CYCLES - 1);
    localparam logic [CNT_W-1:0] PULSE_LOAD = CNT_W'(PULSE_CYCLES - 1);
    localparam logic signed [POS_W-1:0] POS_ONE = POS_W'(1);

    stepper_state_t          r_state;
    logic signed [POS_W-1:0] r_position;
    logic signed [POS_W-1:0] r_target;
    logic                    r_step;
    logic                    r_dir;
    logic                    r_done;
    logic                    r_fin;
    logic                    r_abort_pend;

    logic                    w_need;
    logic                    w_setup_load;
    logic                    w_step_fire;
    logic                    w_blocked;
    logic                    w_load;
    logic [CNT_W-1:0]        w_load_val;
    logic                    w_dec;
    logic                    w_zero;
    logic signed [POS_W-1:0] w_pos_next;

    assign w_need       = cmd_target > r_position;
    assign w_setup_load = (r_state == IDLE) && cmd_valid && (cmd_target != r_position) && (w_need != r_dir);
    assign w_step_fire  = (r_state == WAIT_TICK) && enable_step && !abort && !w_blocked;
    assign w_load       = w_setup_load || w_step_fire;
    assign w_load_val   = w_setup_load ? SETUP_LOAD : PULSE_LOAD;
    assign w_dec        = (r_state == DIR_SETUP) || (r_state == PULSE);
    assign w_pos_next   = r_dir ? r_position + POS_ONE : r_position - POS_ONE;

`ifdef STEPPER_LIMIT_EN
    logic r_fault;

    assign w_blocked = (r_dir && !limit_hi_n) || (!r_dir && !limit_lo_n);
    assign fault     = r_fault;

    // Sticky limit flag, cleared only by an accepted command
    always_ff @(posedge clk_100mhz) begin
        if (!rst_n) r_fault <= 1'b0;
        else if (r_state == IDLE && cmd_valid) r_fault <= 1'b0;
        else if (r_state == WAIT_TICK && enable_step && !abort && w_blocked) r_fault <= 1'b1;
    end
`else
    assign w_blocked = 1'b0;
`endif

    step_pulse_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .i_clk   (clk_100mhz),
        .i_rst_n (rst_n),
        .i_load  (w_load),
        .i_value (w_load_val),
        .i_dec   (w_dec),
        .o_zero  (w_zero)
    );

    // Motion FSM: done is delayed one cycle via r_fin so it follows the falling STEP edge
    always_ff @(posedge clk_100mhz) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_position   <= '0;
            r_target     <= '0;
            r_step       <= 1'b0;
            r_dir        <= 1'b0;
            r_done       <= 1'b0;
            r_fin        <= 1'b0;
            r_abort_pend <= 1'b0;
        end else begin
            r_done <= r_fin;
            r_fin  <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (cmd_valid) begin
                        r_target     <= cmd_target;
                        r_abort_pend <= 1'b0;
                        if (cmd_target == r_position) r_done <= 1'b1;
                        else if (w_need != r_dir) begin
                            r_dir   <= w_need;
                            r_state <= DIR_SETUP;
                        end else r_state <= WAIT_TICK;
                    end
                end
                DIR_SETUP: begin
                    if (abort) r_state <= IDLE;
                    else if (w_zero) r_state <= WAIT_TICK;
                end
                WAIT_TICK: begin
                    if (abort) r_state <= IDLE;
                    else if (enable_step && w_blocked) r_state <= IDLE;
                    else if (enable_step) begin
                        r_step     <= 1'b1;
                        r_position <= w_pos_next;
                        r_state    <= PULSE;
                    end
                end
                PULSE: begin
                    if (abort) r_abort_pend <= 1'b1;
                    if (w_zero) begin
                        r_step       <= 1'b0;
                        r_abort_pend <= 1'b0;
                        r_fin        <= !(r_abort_pend || abort) && (r_position == r_target);
                        r_state      <= (r_abort_pend || abort || r_position == r_target) ? IDLE : WAIT_TICK;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign cmd_ready = (r_state == IDLE);
    assign busy      = (r_state != IDLE);
    assign step_out  = r_step;
    assign dir_out   = r_dir;
    assign done      = r_done;
    assign position  = r_position;

endmodule

// File: tb/tb_stepper_axis_ctrl.sv
// tb_stepper_axis_ctrl: directed scenario bench for stepper_axis_ctrl; limit scenario runs when STEPPER_LIMIT_EN is defined
module tb_stepper_axis_ctrl;
    import stepper_pkg::*;

    logic clk_100mhz = 1'b0;
    logic rst_n = 1'b0;
    logic enable_step = 1'b0;
    logic cmd_valid = 1'b0;
    logic cmd_ready;
    pos_t cmd_target = '0;
    logic abort = 1'b0;
    logic step_out;
    logic dir_out;
    logic busy;
    logic done;
    pos_t position;
`ifdef STEPPER_LIMIT_EN
    logic limit_lo_n = 1'b1;
    logic limit_hi_n = 1'b1;
    logic fault;
`endif

    int checks = 0;
    int passed = 0;
    int cyc = 0;
    int n_rise = 0;
    int n_done = 0;
    int n_badw = 0;
    int hw = 0;
    int last_width = 0;
    int fall_cyc = 0;
    int done_cyc = 0;
    logic prev_step = 1'b0;

    stepper_axis_ctrl dut (
        .clk_100mhz  (clk_100mhz),
        .rst_n       (rst_n),
        .enable_step (enable_step),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_target  (cmd_target),
        .abort       (abort),
        .step_out    (step_out),
        .dir_out     (dir_out),
        .busy        (busy),
        .done        (done),
        .position    (position)
`ifdef STEPPER_LIMIT_EN
        ,
        .limit_lo_n  (limit_lo_n),
        .limit_hi_n  (limit_hi_n),
        .fault       (fault)
`endif
    );

    always #5 clk_100mhz = ~clk_100mhz;

    always @(posedge clk_100mhz) cyc++;

    // Pulse counting and width measurement on the falling clock edge
    always @(negedge clk_100mhz) begin
        if (step_out === 1'b1 && prev_step === 1'b0) n_rise++;
        if (step_out === 1'b1) hw++;
        if (step_out === 1'b0 && prev_step === 1'b1) begin
            last_width = hw;
            fall_cyc = cyc;
            if (hw != 200) n_badw++;
            hw = 0;
        end
        if (done === 1'b1) begin
            n_done++;
            done_cyc = cyc;
        end
        prev_step = step_out;
    end

    task automatic step_clk(input int n);
        repeat (n) begin
            @(posedge clk_100mhz);
            #1;
        end
    endtask

    task automatic send_cmd(input pos_t t);
        cmd_valid = 1'b1;
        cmd_target = t;
        step_clk(1);
        cmd_valid = 1'b0;
    endtask

    task automatic tick();
        enable_step = 1'b1;
        step_clk(1);
        enable_step = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        cmd_valid = 1'b1;
        cmd_target = 16'sd5;
        step_clk(3);
        checks++; if (step_out !== 1'b0) $display("FAIL rst_step: got %b expected 0", step_out); else passed++;
        checks++; if (dir_out !== 1'b0) $display("FAIL rst_dir: got %b expected 0", dir_out); else passed++;
        checks++; if (busy !== 1'b0) $display("FAIL rst_busy: got %b expected 0", busy); else passed++;
        checks++; if (done !== 1'b0) $display("FAIL rst_done: got %b expected 0", done); else passed++;
        checks++; if (position !== 16'sd0) $display("FAIL rst_pos: got %0d expected 0", position); else passed++;
        checks++; if (cmd_ready !== 1'b1) $display("FAIL rst_ready: got %b expected 1", cmd_ready); else passed++;
        cmd_valid = 1'b0;
        rst_n = 1'b1;
        step_clk(2);
        checks++; if (busy !== 1'b0) $display("FAIL rst_no_accept: busy got %b expected 0", busy); else passed++;
    endtask

    task automatic test_move_pos();
        int r0, d0, b0;
        r0 = n_rise; d0 = n_done; b0 = n_badw;
        send_cmd(16'sd3);
        checks++; if (dir_out !== 1'b1) $display("FAIL t1_dir: got %b expected 1", dir_out); else passed++;
        checks++; if (cmd_ready !== 1'b0) $display("FAIL t1_ready_busy: got %b expected 0", cmd_ready); else passed++;
        step_clk(999);
        tick();
        checks++; if (step_out !== 1'b1) $display("FAIL t1_step_latency: got %b expected 1", step_out); else passed++;
        checks++; if (position !== 16'sd1) $display("FAIL t1_pos1: got %0d expected 1", position); else passed++;
        step_clk(999);
        tick();
        step_clk(999);
        tick();
        step_clk(300);
        checks++; if (n_rise - r0 !== 3) $display("FAIL t1_steps: got %0d expected 3", n_rise - r0); else passed++;
        checks++; if (n_badw - b0 !== 0 || last_width !== 200) $display("FAIL t1_width: got %0d expected 200", last_width); else passed++;
        checks++; if (position !== 16'sd3) $display("FAIL t1_pos: got %0d expected 3", position); else passed++;
        checks++; if (n_done - d0 !== 1) $display("FAIL t1_done_count: got %0d expected 1", n_done - d0); else passed++;
        checks++; if (done_cyc !== fall_cyc + 1) $display("FAIL t1_done_timing: got %0d expected %0d", done_cyc, fall_cyc + 1); else passed++;
        checks++; if (busy !== 1'b0) $display("FAIL t1_idle: got %b expected 0", busy); else passed++;
    endtask

    task automatic test_move_neg();
        int r0, d0;
        r0 = n_rise; d0 = n_done;
        send_cmd(-16'sd2);
        checks++; if (dir_out !== 1'b0) $display("FAIL t2_dir: got %b expected 0", dir_out); else passed++;
        for (int i = 0; i < 5; i++) begin
            step_clk(999);
            tick();
        end
        step_clk(300);
        checks++; if (n_rise - r0 !== 5) $display("FAIL t2_steps: got %0d expected 5", n_rise - r0); else passed++;
        checks++; if (position !== -16'sd2) $display("FAIL t2_pos: got %0d expected -2", position); else passed++;
        checks++; if (n_done - d0 !== 1) $display("FAIL t2_done_count: got %0d expected 1", n_done - d0); else passed++;
        r0 = n_rise;
        send_cmd(-16'sd2);
        checks++; if (done !== 1'b1) $display("FAIL t2_same_done: got %b expected 1", done); else passed++;
        step_clk(1);
        checks++; if (done !== 1'b0) $display("FAIL t2_done_pulse: got %b expected 0", done); else passed++;
        tick();
        step_clk(5);
        checks++; if (n_rise - r0 !== 0) $display("FAIL t2_no_step: got %0d expected 0", n_rise - r0); else passed++;
    endtask

    task automatic test_dropped_ticks();
        int r0, d0, b0;
        r0 = n_rise; d0 = n_done; b0 = n_badw;
        send_cmd(16'sd0);
        step_clk(10);
        tick();
        step_clk(20);
        checks++; if (position !== -16'sd2 || n_rise - r0 !== 0) $display("FAIL t3_setup_drop: got pos %0d expected -2", position); else passed++;
        step_clk(150);
        tick();
        checks++; if (position !== -16'sd1) $display("FAIL t3_pos1: got %0d expected -1", position); else passed++;
        step_clk(50);
        tick();
        step_clk(10);
        checks++; if (position !== -16'sd1) $display("FAIL t3_pulse_drop: got %0d expected -1", position); else passed++;
        step_clk(300);
        tick();
        step_clk(300);
        checks++; if (n_rise - r0 !== 2) $display("FAIL t3_steps: got %0d expected 2", n_rise - r0); else passed++;
        checks++; if (position !== 16'sd0) $display("FAIL t3_pos: got %0d expected 0", position); else passed++;
        checks++; if (n_done - d0 !== 1) $display("FAIL t3_done: got %0d expected 1", n_done - d0); else passed++;
        checks++; if (n_badw - b0 !== 0) $display("FAIL t3_width: got %0d bad widths expected 0", n_badw - b0); else passed++;
    endtask

    task automatic test_abort();
        int r0, d0, b0;
        r0 = n_rise; d0 = n_done; b0 = n_badw;
        send_cmd(16'sd5);
        checks++; if (busy !== 1'b1 || dir_out !== 1'b1) $display("FAIL t4_start: got busy %b dir %b expected 1 1", busy, dir_out); else passed++;
        step_clk(999);
        tick();
        step_clk(400);
        send_cmd(16'sd1);
        checks++; if (cmd_ready !== 1'b0) $display("FAIL t4_ready_busy: got %b expected 0", cmd_ready); else passed++;
        step_clk(598);
        tick();
        step_clk(50);
        abort = 1'b1;
        step_clk(1);
        abort = 1'b0;
        checks++; if (step_out !== 1'b1) $display("FAIL t4_pulse_hold: got %b expected 1", step_out); else passed++;
        step_clk(100);
        checks++; if (step_out !== 1'b1 || busy !== 1'b1) $display("FAIL t4_pulse_full: got step %b busy %b expected 1 1", step_out, busy); else passed++;
        step_clk(100);
        checks++; if (step_out !== 1'b0 || busy !== 1'b0) $display("FAIL t4_idle: got step %b busy %b expected 0 0", step_out, busy); else passed++;
        checks++; if (position !== 16'sd2) $display("FAIL t4_pos: got %0d expected 2", position); else passed++;
        checks++; if (n_done - d0 !== 0) $display("FAIL t4_no_done: got %0d expected 0", n_done - d0); else passed++;
        checks++; if (n_badw - b0 !== 0) $display("FAIL t4_width: got %0d bad widths expected 0", n_badw - b0); else passed++;
        tick();
        step_clk(5);
        checks++; if (n_rise - r0 !== 2) $display("FAIL t4_steps: got %0d expected 2", n_rise - r0); else passed++;
        d0 = n_done;
        send_cmd(-16'sd1);
        step_clk(10);
        abort = 1'b1;
        step_clk(1);
        abort = 1'b0;
        checks++; if (busy !== 1'b0) $display("FAIL t4_setup_abort: got busy %b expected 0", busy); else passed++;
        step_clk(5);
        checks++; if (position !== 16'sd2 || n_done - d0 !== 0) $display("FAIL t4_setup_abort_pos: got %0d expected 2", position); else passed++;
    endtask

    task automatic test_reset_mid_pulse();
        send_cmd(16'sd4);
        step_clk(150);
        tick();
        checks++; if (step_out !== 1'b1 || position !== 16'sd3) $display("FAIL t5_step: got step %b pos %0d expected 1 3", step_out, position); else passed++;
        step_clk(50);
        rst_n = 1'b0;
        step_clk(1);
        checks++; if (step_out !== 1'b0) $display("FAIL t5_step_cut: got %b expected 0", step_out); else passed++;
        checks++; if (position !== 16'sd0) $display("FAIL t5_pos: got %0d expected 0", position); else passed++;
        checks++; if (busy !== 1'b0 || dir_out !== 1'b0) $display("FAIL t5_state: got busy %b dir %b expected 0 0", busy, dir_out); else passed++;
        rst_n = 1'b1;
        step_clk(1);
        checks++; if (cmd_ready !== 1'b1) $display("FAIL t5_ready: got %b expected 1", cmd_ready); else passed++;
    endtask

`ifdef STEPPER_LIMIT_EN
    task automatic test_limit();
        int r0, d0;
        r0 = n_rise; d0 = n_done;
        send_cmd(16'sd10);
        for (int i = 0; i < 4; i++) begin
            step_clk(999);
            tick();
        end
        step_clk(300);
        limit_hi_n = 1'b0;
        step_clk(699);
        tick();
        step_clk(5);
        checks++; if (fault !== 1'b1) $display("FAIL t6_fault: got %b expected 1", fault); else passed++;
        checks++; if (position !== 16'sd4) $display("FAIL t6_pos: got %0d expected 4", position); else passed++;
        checks++; if (busy !== 1'b0 || n_done - d0 !== 0) $display("FAIL t6_idle: got busy %b expected 0", busy); else passed++;
        checks++; if (n_rise - r0 !== 4) $display("FAIL t6_steps: got %0d expected 4", n_rise - r0); else passed++;
        limit_hi_n = 1'b1;
        send_cmd(16'sd4);
        checks++; if (fault !== 1'b0) $display("FAIL t6_fault_clear: got %b expected 0", fault); else passed++;
    endtask
`endif

    initial begin
        test_reset();
        test_move_pos();
        test_move_neg();
        test_dropped_ticks();
        test_abort();
        test_reset_mid_pulse();
`ifdef STEPPER_LIMIT_EN
        test_limit();
`endif
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
